// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: request and result handshake bundle for alu_issue_stage.
// master = requester/consumer side, slave = the stage; out_ovf only with ALU_OVF_FLAG_EN.
interface alu_issue_stage_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
`ifdef ALU_OVF_FLAG_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag,
    input  out_zero, out_neg, out_carry
`ifdef ALU_OVF_FLAG_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag,
    output out_zero, out_neg, out_carry
`ifdef ALU_OVF_FLAG_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registers an op onto an external 16-bit alu, captures
// its result one cycle later and offers it on a valid/ready result port.
// Ports: clk, reset (sync, active-high), bus (alu_issue_stage_if.slave:
// in_* request, out_* result), alu_op/alu_a/alu_b to the alu,
// alu_o/alu_cout from the alu, op_count saturating completion counter.
// Optional: ALU_OVF_FLAG_EN adds bus.out_ovf (signed overflow flag).
module alu_issue_stage #(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_stage_if.slave    bus,
  output logic [1:0]          alu_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  input  logic [W-1:0]        alu_o,
  input  logic                alu_cout,
  output logic [15:0]         op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             in_ready_w;
  logic             accept;
  logic             retire;
  logic [TAG_W-1:0] tag_q;
  logic [W-1:0]     res_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             carry_nxt;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_nxt;

  // Held low during reset so nothing can be accepted while state is unknown.
  assign in_ready_w = !reset &&
    ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_w;
  assign retire     = (state == DONE) && bus.out_ready;

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = res_q;
  assign bus.out_tag    = res_tag_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_neg    = neg_q;
  assign bus.out_carry  = carry_q;
  assign op_count       = cnt_q;

  // Logic ops (op 1x) never report a carry, whatever the alu drives.
  assign carry_nxt = !alu_op[1] && alu_cout;

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q;
  logic ovf_nxt;

  always_comb begin
    ovf_nxt = 1'b0;
    unique case (1'b1)
      (alu_op == 2'b00):
        ovf_nxt = (alu_a[W-1] == alu_b[W-1]) &&
                  (alu_o[W-1] != alu_a[W-1]);
      (alu_op == 2'b01):
        ovf_nxt = (alu_a[W-1] != alu_b[W-1]) &&
                  (alu_o[W-1] != alu_a[W-1]);
      default: ovf_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (state == EXEC)
      ovf_q <= ovf_nxt;
  end

  assign bus.out_ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: if (bus.out_ready)
              state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers: loaded only on accept.
  // tag_q is separate from res_tag_q so a back-to-back accept in DONE
  // cannot disturb the tag still being presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      tag_q  <= '0;
    end else if (accept) begin
      alu_op <= bus.in_op;
      alu_a  <= bus.in_a;
      alu_b  <= bus.in_b;
      tag_q  <= bus.in_tag;
    end
  end

  // Result registers: captured at the end of the single EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q     <= '0;
      res_tag_q <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      carry_q   <= 1'b0;
    end else if (state == EXEC) begin
      res_q     <= alu_o;
      res_tag_q <= tag_q;
      zero_q    <= (alu_o == '0);
      neg_q     <= alu_o[W-1];
      carry_q   <= carry_nxt;
    end
  end

  assign cnt_nxt = (retire && (cnt_q != 16'hFFFF)) ?
                   cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_nxt;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: vector table, corner sequences and random traffic
// against a behavioural model of the issue stage and a simple alu.
module tb_alu_issue_stage;
  localparam int W     = 16;
  localparam int TAG_W = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_o;
  logic          alu_cout;
  logic [15:0]   op_count;
  logic          junk_cout;

  int errs  = 0;
  int n_chk = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.W(W), .TAG_W(TAG_W)) bus ();

  alu_issue_stage #(.W(W), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_o    (alu_o),
    .alu_cout (alu_cout),
    .op_count (op_count)
  );

  // The combinational alu the stage drives; logic ops report an
  // arbitrary carry so the stage's carry masking is exercised.
  always_comb begin
    logic [16:0] s;
    s = '0;
    alu_o = '0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_o = s[15:0];
        alu_cout = s[16];
      end
      2'b01: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_o = s[15:0];
        alu_cout = s[16];
      end
      2'b10: begin
        alu_o = alu_a & alu_b;
        alu_cout = junk_cout;
      end
      default: begin
        alu_o = alu_a | alu_b;
        alu_cout = junk_cout;
      end
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } vec_t;

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic vec_t model(logic [1:0] op, logic [15:0] a,
                                 logic [15:0] b, logic [3:0] tag);
    vec_t e;
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    e.op = op; e.a = a; e.b = b; e.tag = tag;
    e.c = 1'b0; e.v = 1'b0;
    case (op)
      2'b00: begin
        e.res = 16'((ua + ub) % 65536);
        e.c = (ua + ub) > 65535;
        sr = sa + sb;
        e.v = (sr > 32767) || (sr < -32768);
      end
      2'b01: begin
        e.res = 16'((ua - ub + 65536) % 65536);
        e.c = (ua >= ub);
        sr = sa - sb;
        e.v = (sr > 32767) || (sr < -32768);
      end
      2'b10: e.res = a & b;
      default: e.res = a | b;
    endcase
    e.z = (e.res == 16'h0000);
    e.n = e.res[15];
    return e;
  endfunction

  function automatic int sat_inc(int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(vec_t e);
    chk("result", 32'(bus.out_result), 32'(e.res));
    chk("tag",    32'(bus.out_tag),    32'(e.tag));
    chk("zero",   32'(bus.out_zero),   32'(e.z));
    chk("neg",    32'(bus.out_neg),    32'(e.n));
    chk("carry",  32'(bus.out_carry),  32'(e.c));
`ifdef ALU_OVF_FLAG_EN
    chk("ovf",    32'(bus.out_ovf),    32'(e.v));
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(vec_t v);
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_op  = v.op;
    bus.in_a   = v.a;
    bus.in_b   = v.b;
    bus.in_tag = v.tag;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(vec_t v, string name);
    int lat;
    issue(v);
    lat = 1;
    chk({name, "_alu_a"}, 32'(alu_a), 32'(v.a));
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd2);
    check_out(v);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    chk({name, "_count"}, 32'(op_count), 32'(exp_cnt));
    chk({name, "_vld_low"}, 32'(bus.out_valid), 32'd0);
  endtask

  vec_t tbl [8];
  vec_t e1, e2;
  vec_t req;
  vec_t sbq [$];

  initial begin
    tbl[0] = '{2'b00, 16'h7FFF, 16'h0001, 4'd3,
               16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{2'b01, 16'h0005, 16'h0005, 4'd1,
               16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2'b01, 16'h0003, 16'h0005, 4'd2,
               16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'b10, 16'hF0F0, 16'hFF00, 4'd4,
               16'hF000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2'b11, 16'hF0F0, 16'h0F00, 4'd5,
               16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2'b00, 16'hFFFF, 16'h0001, 4'd6,
               16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{2'b01, 16'h8000, 16'h0001, 4'd7,
               16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{2'b00, 16'h8000, 16'h8000, 4'd15,
               16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    junk_cout = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),   32'd0);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_alu_a",     32'(alu_a),          32'd0);
    chk("rst_result",    32'(bus.out_result), 32'd0);
    chk("rst_count",     32'(op_count),       32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Vector table; logic ops see alu_cout=1 from the alu.
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure in DONE with a waiting request, then back-to-back.
    e1 = model(2'b00, 16'h1234, 16'h1111, 4'd9);
    e2 = model(2'b01, 16'h0003, 16'h0005, 4'd10);
    issue(e1);
    @(negedge clk);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op = e2.op;
    bus.in_a = e2.a;
    bus.in_b = e2.b;
    bus.in_tag = e2.tag;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_out(e1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    chk("bp_count", 32'(op_count), 32'(exp_cnt));
    chk("b2b_exec_vld", 32'(bus.out_valid), 32'd0);
    chk("b2b_alu_b", 32'(alu_b), 32'(e2.b));
    @(negedge clk);
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    check_out(e2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    chk("b2b_count", 32'(op_count), 32'(exp_cnt));

    // Reset while the op is in EXEC: nothing comes out.
    issue(model(2'b00, 16'h0100, 16'h0200, 4'd2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    chk("exec_rst_valid",  32'(bus.out_valid),  32'd0);
    chk("exec_rst_count",  32'(op_count),       32'd0);
    chk("exec_rst_result", 32'(bus.out_result), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exec_rst_quiet", 32'(bus.out_valid), 32'd0);
    end
    chk("exec_rst_count2", 32'(op_count), 32'd0);
    bus.out_ready = 1'b0;

    // Counter saturation: preset just below the limit.
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 65534;
    run_vec(model(2'b10, 16'h00FF, 16'h0F0F, 4'd1), "sat1");
    run_vec(model(2'b11, 16'h0000, 16'h0000, 4'd2), "sat2");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);

    // Random traffic with random backpressure against a scoreboard.
    begin
      int issued, done, cyc;
      bit pending;
      vec_t e;
      issued = 0; done = 0; cyc = 0; pending = 1'b0;
      while ((done < 60) && (cyc < 3000)) begin
        @(negedge clk);
        cyc++;
        junk_cout = 1'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (!pending) begin
          bus.in_valid = 1'b0;
          if ((issued < 60) && ($urandom_range(0, 2) != 0)) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) rb = ra;
            req = model(2'($urandom), ra, rb, 4'($urandom));
            bus.in_op = req.op;
            bus.in_a = req.a;
            bus.in_b = req.b;
            bus.in_tag = req.tag;
            bus.in_valid = 1'b1;
            pending = 1'b1;
          end
        end
        #1;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            chk("rand_spurious", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check_out(e);
            exp_cnt = sat_inc(exp_cnt);
            done++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          sbq.push_back(req);
          issued++;
          pending = 1'b0;
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("rand_done", 32'(done), 32'd60);
      chk("rand_count", 32'(op_count), 32'(exp_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
